// File: rtl/sa_pkg.sv
// Shared types and vector helpers for the switch-allocator requester client.
package sa_pkg;
  localparam int NPORT = 4;

  typedef logic [1:0] port_idx_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return popcount4(v) == 3'd1;
  endfunction

  function automatic port_idx_t onehot_idx4(input logic [3:0] v);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < NPORT; i++)
      if (v[i]) idx = port_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/sa_req_fifo.sv
// Per-port payload FIFO: refuses pushes while full, head is the oldest entry.
module sa_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  // Fullness is judged before any same-cycle pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sa_req_client_4x4.sv
// Requester side of the 4-port rotating-token switch allocator: buffers port
// payloads, requests, registers the granted payload and flags arbiter misbehaviour.
module sa_req_client_4x4 import sa_pkg::*; #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  in_valid,
  input  logic [4*DW-1:0]   in_data,
  output logic [NPORT-1:0]  in_ready,
  output logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  ack,
  output logic              out_valid,
  output logic [1:0]        out_port,
  output logic [DW-1:0]     out_data,
  input  logic              out_ready,
  output logic              err_proto,
  output logic [NPORT-1:0]  err_starve
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [NPORT-1:0] full, empty, pop, gnt_p0;
  logic [DW-1:0]    head [NPORT];
  logic             out_free, ack_bad, grant_ok;
  port_idx_t        gnt_idx;
  logic [WW-1:0]    wait_cnt [NPORT];

  for (genvar i = 0; i < NPORT; i++) begin : g_fifo
    sa_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i]),
      .push_data (in_data[i*DW +: DW]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign in_ready = ~full;
  // The arbiter grants unconditionally, so requests are withheld while the output stalls.
  assign out_free = ~out_valid | out_ready;
  assign req      = ~empty & {NPORT{out_free}};

  assign gnt_p0   = ack & req;
  assign ack_bad  = (|(ack & ~req)) | (popcount4(ack) > 3'd1);
  assign grant_ok = ~ack_bad & is_onehot4(gnt_p0);
  assign pop      = grant_ok ? gnt_p0 : '0;
  assign gnt_idx  = onehot_idx4(gnt_p0);

  // Stage boundary: grant decode -> registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_port  <= '0;
      out_data  <= '0;
      err_proto <= 1'b0;
    end else begin
      if (ack_bad) err_proto <= 1'b1;
      if (grant_ok) begin
        out_valid <= 1'b1;
        out_port  <= gnt_idx;
        out_data  <= head[gnt_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) wait_cnt[i] <= '0;
      err_starve <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (req[i] && !ack[i]) begin
          if (wait_cnt[i] != WW'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + WW'(1);
          if (wait_cnt[i] >= WW'(MAX_WAIT - 1)) err_starve[i] <= 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sa_req_client_4x4.sv
// Bench for sa_req_client_4x4: rotating-token arbiter partner, queue-based
// reference model and a scoreboard on the shared output.
module tb_sa_req_client_4x4;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 15;

  logic            clk;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic [3:0]      ack;
  logic            out_valid;
  logic [1:0]      out_port;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            err_proto;
  logic [3:0]      err_starve;

  int errors = 0;
  int checks = 0;

  sa_req_client_4x4 #(.DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .req        (req),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_port   (out_port),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .err_proto  (err_proto),
    .err_starve (err_starve)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Arbiter partner: 0 = rotating token, 1 = fixed driver ack, 2 = mix of token and random acks.
  logic [1:0] drv_mode;
  logic [3:0] drv_ack, rnd_ack, arb_ack;
  logic       rnd_sel;
  logic [1:0] tok, arb_idx, arb_c;

  always_comb begin
    arb_ack = '0;
    arb_idx = tok;
    arb_c   = tok;
    for (int j = 0; j < 4; j++) begin
      arb_c = tok + 2'(j);
      if (arb_ack == 4'd0 && req[arb_c]) begin
        arb_ack[arb_c] = 1'b1;
        arb_idx = arb_c;
      end
    end
    case (drv_mode)
      2'd1:    ack = drv_ack;
      2'd2:    ack = rnd_sel ? rnd_ack : arb_ack;
      default: ack = arb_ack;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) tok <= 2'd0;
    else if (drv_mode == 2'd0 && arb_ack != 4'd0) tok <= arb_idx + 2'd1;
  end

  // Reference model: one queue per port plus the shared output register.
  logic [DW-1:0]   mq [4][$];
  logic [DW+1:0]   exp_q [$];
  logic            ov_m;
  logic            ep_m;
  logic [3:0]      es_m, req_m, rdy_m, full_m;
  int              wait_m [4];

  initial begin
    logic          legal;
    int            gk;
    logic [DW-1:0] d;
    ov_m = 0; ep_m = 0; es_m = 0;
    for (int i = 0; i < 4; i++) wait_m[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mq[i].delete();
          wait_m[i] = 0;
        end
        exp_q.delete();
        ov_m = 0; ep_m = 0; es_m = 0;
      end
      for (int i = 0; i < 4; i++) begin
        req_m[i]  = (mq[i].size() != 0) && (!ov_m || out_ready);
        rdy_m[i]  = mq[i].size() < DEPTH;
        full_m[i] = !rdy_m[i];
      end
      chk("req", 32'(req), 32'(req_m));
      chk("in_ready", 32'(in_ready), 32'(rdy_m));
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      chk("err_proto", 32'(err_proto), 32'(ep_m));
      chk("err_starve", 32'(err_starve), 32'(es_m));
      if (!rst) begin
        legal = ((ack & ~req_m) == 4'd0) && ($countones(ack) <= 1);
        if (!legal) ep_m = 1;
        for (int i = 0; i < 4; i++) begin
          if (req_m[i] && !ack[i]) begin
            if (wait_m[i] < MAX_WAIT) wait_m[i]++;
            if (wait_m[i] == MAX_WAIT) es_m[i] = 1'b1;
          end else begin
            wait_m[i] = 0;
          end
        end
        gk = -1;
        if (legal && ack != 4'd0)
          for (int i = 0; i < 4; i++) if (ack[i]) gk = i;
        if (gk >= 0) begin
          d = mq[gk].pop_front();
          exp_q.push_back({2'(gk), d});
          ov_m = 1;
        end else if (out_ready) begin
          ov_m = 0;
        end
        for (int i = 0; i < 4; i++)
          if (in_valid[i] && !full_m[i]) mq[i].push_back(in_data[i*DW +: DW]);
      end
    end
  end

  // Scoreboard monitor: every accepted output beat must match the oldest predicted grant.
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_port", 32'(out_port), 32'(e[DW+1:DW]));
          chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; in_valid = 0; in_data = 0; out_ready = 0;
    drv_mode = 0; drv_ack = 0; rnd_sel = 0; rnd_ack = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_port", 32'(out_port), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    rst = 0;

    // Single push on port 2
    out_ready = 1;
    in_valid = 4'b0100;
    in_data[2*DW +: DW] = 8'hA5;
    tick();
    in_valid = 0;
    chk("t1_req", 32'(req), 32'b0100);
    tick();
    chk("t1_valid", 32'(out_valid), 32'(1));
    chk("t1_port", 32'(out_port), 32'(2));
    chk("t1_data", 32'(out_data), 32'hA5);
    repeat (3) tick();

    // One entry on every port
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = 8'(8'h10 + i);
    tick();
    in_valid = 0;
    repeat (8) tick();
    chk("t2_req_idle", 32'(req), 32'(0));
    chk("t2_empty", 32'(in_ready), 32'hF);

    // Two entries on port 0 with a stall after the first beat
    in_valid = 4'b0001;
    in_data[0 +: DW] = 8'h31;
    tick();
    in_data[0 +: DW] = 8'h32;
    tick();
    in_valid = 0;
    out_ready = 0;
    repeat (3) tick();
    chk("t3_req_masked", 32'(req), 32'(0));
    chk("t3_hold_data", 32'(out_data), 32'h31);
    out_ready = 1;
    tick();
    chk("t3_second_valid", 32'(out_valid), 32'(1));
    chk("t3_second_data", 32'(out_data), 32'h32);
    repeat (3) tick();

    // Fill port 1 while the output is stalled
    out_ready = 0;
    in_valid = 4'b0001;
    in_data[0 +: DW] = 8'h40;
    tick();
    in_valid = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b0010;
      in_data[DW +: DW] = 8'(8'h50 + k);
      tick();
      if (k == 3) chk("t4_full", 32'(in_ready[1]), 32'(0));
    end
    in_valid = 0;
    chk("t4_still_full", 32'(in_ready[1]), 32'(0));
    out_ready = 1;
    repeat (8) tick();

    // Illegal acks from the driver
    drv_mode = 1;
    drv_ack = 0;
    in_valid = 4'b0001;
    in_data[0 +: DW] = 8'h60;
    tick();
    in_valid = 0;
    drv_ack = 4'b0010;
    tick();
    chk("t5_proto", 32'(err_proto), 32'(1));
    drv_ack = 4'b0011;
    tick();
    chk("t5_no_out", 32'(out_valid), 32'(0));
    chk("t5_pending", 32'(req), 32'b0001);
    drv_ack = 0;
    rst = 1;
    tick();
    rst = 0;

    // Starvation of port 3, then reset mid-burst
    out_ready = 1;
    in_valid = 4'b1000;
    in_data[3*DW +: DW] = 8'h70;
    tick();
    in_valid = 0;
    repeat (16) tick();
    chk("t6_starve", 32'(err_starve), 32'b1000);
    #2 rst = 1;
    #1;
    chk("t6_rst_starve", 32'(err_starve), 32'(0));
    chk("t6_rst_req", 32'(req), 32'(0));
    chk("t6_rst_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_proto", 32'(err_proto), 32'(0));
    @(posedge clk);
    #1 rst = 0;
    drv_mode = 0;

    // Random traffic against the rotating-token arbiter
    for (int n = 0; n < 2000; n++) begin
      in_valid = 4'($urandom) & 4'($urandom);
      in_data = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Random traffic with occasional illegal acks
    drv_mode = 2;
    for (int n = 0; n < 300; n++) begin
      in_valid = 4'($urandom);
      in_data = 32'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd_sel = ($urandom_range(0, 4) == 0);
      rnd_ack = 4'($urandom);
      tick();
    end

    drv_mode = 0;
    rnd_sel = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (30) tick();
    chk("drain_scoreboard", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
